// File: rtl/avalon_sev_seg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sev_seg_pkg : register map and hex-to-segment table for avalon_sev_seg_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sev_seg_pkg;

  localparam logic [3:0] ADDR_DATA     = 4'd0;
  localparam logic [3:0] ADDR_MODE     = 4'd1;
  localparam logic [3:0] ADDR_BLANK    = 4'd2;
  localparam logic [3:0] ADDR_BLINK    = 4'd3;
  localparam logic [3:0] ADDR_SET      = 4'd4;
  localparam logic [3:0] ADDR_CLR      = 4'd5;
  localparam logic [3:0] ADDR_STATUS   = 4'd6;
  localparam logic [3:0] ADDR_RAW_BASE = 4'd8;

  // Active-high g..a patterns, entry 0 in the least significant slot
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

`default_nettype wire

// File: rtl/avalon_sev_seg_ctrl_if.sv
// ---------------------------------------------------------------------------
// avalon_sev_seg_ctrl_if : Avalon-MM slave bus for the seven-segment controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface avalon_sev_seg_ctrl_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, read_n, writedata,
                  input  readdata);
  modport slave  (input  address, chipselect, write_n, read_n, writedata,
                  output readdata);
endinterface

`default_nettype wire

// File: rtl/avalon_sev_seg_ctrl_hex_to_sev_seg.sv
// ---------------------------------------------------------------------------
// hex_to_sev_seg : combinational nibble to active-high a..g decoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_to_sev_seg
  import sev_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_TABLE[i_nib];

endmodule

`default_nettype wire

// File: rtl/avalon_sev_seg_ctrl.sv
// ---------------------------------------------------------------------------
// avalon_sev_seg_ctrl : Avalon-MM seven-segment controller with per-digit
// hex/raw mode, blank and blink masks, and set/clear data access. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module avalon_sev_seg_ctrl
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SEG_W      = 7,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                        clk,
  input  logic                        reset,
  avalon_sev_seg_ctrl_if.slave        bus,
  output logic [NUM_DIGITS*SEG_W-1:0] seg_out
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [DW-1:0]                  r_data;
  logic [NUM_DIGITS-1:0]          r_mode;
  logic [NUM_DIGITS-1:0]          r_blank;
  logic [NUM_DIGITS-1:0]          r_blink;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_phase;
  logic [NUM_DIGITS*SEG_W-1:0]    r_seg;
  logic [NUM_DIGITS*SEG_W-1:0]    w_seg_nxt;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] w_raw_rd;
  logic                           w_wr;
  logic [DW-1:0]                  w_wdata;
  logic [31:0]                    w_rdata;
  logic                           w_unused;

  assign w_wr     = bus.chipselect & ~bus.write_n;
  assign w_wdata  = bus.writedata[DW-1:0];
  assign w_unused = ^{bus.read_n, bus.writedata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_mode  <= '0;
      r_blank <= '0;
      r_blink <= '0;
    end else if (w_wr) begin
      case (bus.address)
        ADDR_DATA:  r_data  <= w_wdata;
        ADDR_MODE:  r_mode  <= bus.writedata[NUM_DIGITS-1:0];
        ADDR_BLANK: r_blank <= bus.writedata[NUM_DIGITS-1:0];
        ADDR_BLINK: r_blink <= bus.writedata[NUM_DIGITS-1:0];
        ADDR_SET:   r_data  <= r_data | w_wdata;
        ADDR_CLR:   r_data  <= r_data & ~w_wdata;
        default:    ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam logic [3:0] RAW_ADDR = 4'(ADDR_RAW_BASE + i);

    logic [SEG_W-1:0] r_raw;
    logic [6:0]       w_hex;
    logic [6:0]       w_src;
    logic [SEG_W-1:0] w_full;
    logic             w_off;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        r_raw <= '0;
      else if (w_wr && bus.address == RAW_ADDR)
        r_raw <= bus.writedata[SEG_W-1:0];
    end

    hex_to_sev_seg u_hex (
      .i_nib (r_data[4*i +: 4]),
      .o_seg (w_hex)
    );

    assign w_src = r_mode[i] ? w_hex : r_raw[6:0];

    // Decimal point is always taken from the raw register, even in hex mode
    if (SEG_W == 8) begin : g_dp
      assign w_full = {r_raw[SEG_W-1], w_src};
    end else begin : g_nodp
      assign w_full = w_src;
    end

    assign w_off = r_blank[i] | (r_blink[i] & r_phase);
    assign w_seg_nxt[i*SEG_W +: SEG_W] = w_off ? '1 : ~w_full;
    assign w_raw_rd[i] = (bus.address == RAW_ADDR) ? r_raw : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_seg   <= '1;
    end else begin
      r_seg <= w_seg_nxt;
      if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA:   w_rdata = 32'(r_data);
      ADDR_MODE:   w_rdata = 32'(r_mode);
      ADDR_BLANK:  w_rdata = 32'(r_blank);
      ADDR_BLINK:  w_rdata = 32'(r_blink);
      ADDR_STATUS: begin
        w_rdata[0]    = r_phase;
        w_rdata[11:8] = 4'(NUM_DIGITS);
      end
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++)
          w_rdata = w_rdata | 32'(w_raw_rd[i]);
      end
    endcase
  end

  assign bus.readdata = w_rdata;
  assign seg_out      = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_avalon_sev_seg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_avalon_sev_seg_ctrl : scoreboard bench for avalon_sev_seg_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_avalon_sev_seg_ctrl;
  localparam int ND = 6;
  localparam int SW = 8;
  localparam int BD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [ND*SW-1:0] seg_out;

  always #5 clk = ~clk;

  avalon_sev_seg_ctrl_if bus ();

  avalon_sev_seg_ctrl #(.NUM_DIGITS(ND), .SEG_W(SW), .BLINK_DIV(BD)) dut (
    .clk     (clk),
    .reset   (rst),
    .bus     (bus),
    .seg_out (seg_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  // Independent blink-phase reference; m_ph_d is the phase seen by the last edge
  int   m_cnt;
  logic m_ph, m_ph_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_ph   <= 1'b0;
      m_ph_d <= 1'b0;
    end else begin
      m_ph_d <= m_ph;
      if (m_cnt == BD - 1) begin
        m_cnt <= 0;
        m_ph  <= ~m_ph;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input logic [63:0] obs);
    exp_t x;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: observed %0h expected none", obs);
    end else begin
      x = sb.pop_front();
      check(x.tag, obs, x.exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.read_n     = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] e);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    bus.write_n    = 1'b1;
    push_exp(tag, 64'(e));
    #1 pop_cmp(64'(bus.readdata));
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
  endtask

  task automatic seg_chk(input string tag, input logic [ND*SW-1:0] e);
    @(negedge clk);
    push_exp(tag, 64'(e));
    #1 pop_cmp(64'(seg_out));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  found;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
    rst            = 1'b1;

    // Reset state, checked while reset is held
    repeat (3) @(negedge clk);
    seg_chk("rst_seg", '1);
    rd("rst_data",   4'd0, 32'h0);
    rd("rst_mode",   4'd1, 32'h0);
    rd("rst_blank",  4'd2, 32'h0);
    rd("rst_blink",  4'd3, 32'h0);
    rd("rst_status", 4'd6, 32'h600);
    @(negedge clk);
    rst = 1'b0;

    // Hex decode on all digits; dp stays off so bit7 of every digit is 1
    wr(4'd1, 32'h3F);
    wr(4'd0, 32'h123456);
    seg_chk("hex_seg", 48'hF9A4B0999282);
    rd("data_rb", 4'd0, 32'h123456);

    // Raw mode with only the decimal point lit on digit 2
    wr(4'd10, 32'h80);
    wr(4'd1, 32'h0);
    seg_chk("raw_dp", 48'hFFFFFF7FFFFF);
    rd("raw2_rb", 4'd10, 32'h80);

    // Out-of-range raw slot, unmapped address, DATA truncation
    wr(4'd14, 32'h55);
    rd("raw6_ign", 4'd14, 32'h0);
    wr(4'd7, 32'hFFFF);
    rd("addr7", 4'd7, 32'h0);
    wr(4'd0, 32'hFFFFFFFF);
    rd("data_trunc", 4'd0, 32'h00FFFFFF);

    // Atomic set / clear
    wr(4'd0, 32'h00F0F0);
    wr(4'd4, 32'h000F00);
    rd("data_set", 4'd0, 32'h00FFF0);
    wr(4'd5, 32'h0000F0);
    rd("data_clr", 4'd0, 32'h00FF00);
    rd("set_rd", 4'd4, 32'h0);
    rd("clr_rd", 4'd5, 32'h0);

    // Read and write the same register in one cycle
    @(negedge clk);
    bus.address    = 4'd1;
    bus.writedata  = 32'h2A;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.read_n     = 1'b0;
    push_exp("rdw_old", 64'h0);
    #1 pop_cmp(64'(bus.readdata));
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read_n     = 1'b1;
    rd("rdw_new", 4'd1, 32'h2A);

    // Blink digit 0 showing hex 8
    wr(4'd1, 32'h01);
    wr(4'd0, 32'h8);
    wr(4'd3, 32'h01);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.address    = 4'd6;
      bus.chipselect = 1'b1;
      bus.read_n     = 1'b0;
      push_exp("blink_d0", m_ph_d ? 64'hFF : 64'h80);
      push_exp("blink_status", 64'h600 | 64'(m_ph));
      #1;
      pop_cmp(64'(seg_out[7:0]));
      pop_cmp(64'(bus.readdata));
    end
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;

    // BLANK overrides BLINK
    wr(4'd2, 32'h01);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.address    = 4'd6;
      bus.chipselect = 1'b1;
      bus.read_n     = 1'b0;
      push_exp("blank_d0", 64'hFF);
      push_exp("blank_status", 64'h600 | 64'(m_ph));
      #1;
      pop_cmp(64'(seg_out[7:0]));
      pop_cmp(64'(bus.readdata));
    end
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    wr(4'd2, 32'h00);

    // Asynchronous reset at count 2, phase 1
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_cnt == 2 && m_ph == 1'b1) found = 1'b1;
    end
    check("midrst_found", 64'(found), 64'h1);
    rst = 1'b1;
    push_exp("midrst_seg", {64{1'b1}} >> (64 - ND*SW));
    #1 pop_cmp(64'(seg_out));
    repeat (3) @(negedge clk);
    rst            = 1'b0;
    bus.address    = 4'd6;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    k     = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.readdata[0]) begin
        found = 1'b1;
        k     = i;
      end
    end
    check("first_toggle", 64'(k), 64'(BD));
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/avalon_sev_seg_ctrl.md
Name: avalon_sev_seg_ctrl

Overview:
Parametrised Avalon-MM slave that drives NUM_DIGITS seven-segment digits. It replaces the single 32-bit write-only PIO data register with per-digit raw/hex-decode mode, blank and blink masks, and atomic set/clear access to the data register. It sits on the HPS/Nios Avalon-MM interconnect. Its seg_out pins connect directly to the board's active-low HEX displays.

Parameters:
NUM_DIGITS, 6, number of digits driven (1..8)
SEG_W, 7, segments per digit: 7 = a..g, 8 = a..g plus dp in bit 7
BLINK_DIV, 25000000, clk cycles per blink half-period (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  4  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
read_n  in  1  active-low read strobe (readdata is valid regardless)
writedata  in  32  write data
readdata  out  32  read data, combinational, zero read latency
seg_out  out  NUM_DIGITS*SEG_W  active-low segments; digit i occupies [i*SEG_W +: SEG_W]

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high. No waitrequest. A write occurs when chipselect && !write_n.
- Register map. Unused bits read 0. Addresses not listed read 0 and ignore writes.
  - 0 DATA, RW, 4*NUM_DIGITS bits: nibble i is the hex value for digit i.
  - 1 MODE, RW, NUM_DIGITS bits: bit i = 1 selects hex decode for digit i; 0 selects raw.
  - 2 BLANK, RW, NUM_DIGITS bits: bit i = 1 turns digit i fully off.
  - 3 BLINK, RW, NUM_DIGITS bits: bit i = 1 blanks digit i while phase = 1.
  - 4 DATA_SET, WO: DATA <= DATA | writedata. Reads 0.
  - 5 DATA_CLR, WO: DATA <= DATA & ~writedata. Reads 0.
  - 6 STATUS, RO: bit0 = blink phase; bits[11:8] = NUM_DIGITS.
  - 8+i RAW[i], RW, SEG_W bits, i < NUM_DIGITS: active-high segment enables for digit i. Bit0 = a … bit6 = g, bit7 = dp.
- Reset: all registers 0, blink counter 0, phase 0, seg_out all ones (every digit dark).
- Write latency: the register updates on the edge ending the write cycle. seg_out is registered, so it reflects the change one edge later (2 edges after the write is presented).
- Segment generation per digit i:
  - Source: if MODE[i], source = hex_decode(DATA nibble i); else source = RAW[i][6:0].
  - dp (SEG_W=8 only) always comes from RAW[i][7], in both modes.
  - on = BLANK[i] | (BLINK[i] & phase).
  - seg_out digit = on ? all ones : ~source.
- Hex table (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Blink counter:
  - Free-running, counts 0..BLINK_DIV-1. On the edge where count == BLINK_DIV-1 it wraps to 0 and phase toggles.
  - Width is $clog2(BLINK_DIV).
  - Unaffected by register writes; only reset clears it.
- Boundaries:
  - BLANK overrides BLINK.
  - Writes beyond the DATA width are truncated.
  - Writing RAW[i] for i >= NUM_DIGITS is ignored.
  - Reset asserted mid-blink restarts at count 0, phase 0.
  - A read and a write to the same address in one cycle returns the pre-write value.

Decomposition:
- Package sev_seg_pkg holds:
  - address constants: ADDR_DATA, ADDR_MODE, ADDR_BLANK, ADDR_BLINK, ADDR_SET, ADDR_CLR, ADDR_STATUS, ADDR_RAW_BASE
  - the 16-entry hex-to-segment table constant
- One sub-module, hex_to_sev_seg: combinational, 4-bit in, 7-bit active-high out. Instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Reset: assert reset for 3 cycles -> seg_out = all ones; read addresses 0..3 -> 0; STATUS = 0x600.
- Hex mode: write MODE = 0x3F, DATA = 0x123456 -> 2 edges later digit0 = ~0x7D = 0x02 ("6") and digit5 = ~0x06 = 0x79 ("1"); readback DATA = 0x123456.
- Raw mode with dp (SEG_W=8): write RAW[2] = 0x80, MODE = 0 -> digit2 = 0x7F, other digits = 0xFF.
- Set/clear: starting from DATA = 0x00F0F0, write DATA_SET 0x000F00 -> DATA = 0x00FFF0; then write DATA_CLR 0x0000F0 -> DATA = 0x00FF00; reads of addresses 4 and 5 return 0.
- Blink (BLINK_DIV=4): MODE = 0x01, DATA = 0x8, BLINK = 0x01 -> digit0 alternates 0x00 / 0x7F every 4 cycles. Then set BLANK = 0x01 -> digit0 = 0x7F constantly. STATUS bit0 toggles every 4 cycles throughout.
- Reset mid-operation: assert reset at count 2, phase 1 -> seg_out dark immediately (asynchronous); after release, first phase toggle occurs exactly BLINK_DIV cycles later.
